trilat_pair_scheduler: RTL and testbench
========================================

Name: trilat_pair_scheduler

Overview:
- Sequences one shared circle-intersection datapath across the three anchor pairs of a trilateration solve.
- Latches three anchors (x, y, r) on start and issues the pairs (0,1), (0,2), (1,2) to the datapath in that order.
- Waits a fixed datapath latency for each pair, captures both intersection points into a result bank, and pulses done.
- Sits between the anchor-load front end and the point-selection/centroid stage.

Parameters:
- N, 8, anchor coordinate width (signed); radius width is N+1; result point width is N+2.
- LAT, 2, cycles from operand issue to stable datapath result; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a solve; accepted only in IDLE
- ax  in  3*N  anchor x coordinates; anchor i occupies bits [i*N +: N], signed
- ay  in  3*N  anchor y coordinates, same packing
- ar  in  3*(N+1)  anchor radii; anchor i occupies bits [i*(N+1) +: N+1], signed
- xK, yK, xL, yL  out  N each  registered operands to the datapath
- rK, rL  out  N+1 each  registered operands to the datapath
- op_valid  out  1  high while operands are held for the datapath (ISSUE and WAIT)
- x1P, y1P, x2P, y2P  in  N+2 each  datapath results
- pts_x  out  6*(N+2)  captured x results; slot s occupies [s*(N+2) +: N+2]
- pts_y  out  6*(N+2)  captured y results, same packing
- pair_valid  out  3  bit j set when pair j has been captured
- deg_flag  out  3  bit j set when pair j is degenerate (xL == xK) and was skipped
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of solve

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; pair counter and wait counter cleared.
  - All operand outputs, pts_x, pts_y, pair_valid, deg_flag, op_valid, busy and done go to 0.
  - Reset takes effect from any state, mid-solve included; a reset in the same cycle as start wins.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - On start=1, latch ax/ay/ar and clear pair_valid, deg_flag, pts_x and pts_y.
  - Set pair index j=0 and go to ISSUE.
  - start in any other state is ignored.
- Pair map: j=0 drives K=anchor0, L=anchor1; j=1 drives K=0, L=2; j=2 drives K=1, L=2.
- ISSUE (1 cycle):
  - Operand registers already hold pair j (loaded on the transition into ISSUE); op_valid=1.
  - If the latched xL == xK: set deg_flag[j] and leave slots 2j and 2j+1 at 0. Go to ISSUE for j+1, or to DONE if j=2. The datapath result is not waited for (its divide is undefined).
  - Otherwise load the wait counter with LAT and go to WAIT.
- WAIT: op_valid=1 and operands held stable; lasts exactly LAT cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - op_valid=1; sample x1P/y1P into slot 2j and x2P/y2P into slot 2j+1; set pair_valid[j].
  - Go to ISSUE for j+1 (operands reloaded on this edge), or to DONE if j=2.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Timing:
  - A non-degenerate pair costs LAT+2 cycles; a degenerate pair costs 1 cycle.
  - With start sampled at edge 0, done is high in cycle 1 + sum over pairs of their cost. For three normal pairs that is cycle 1+3*(LAT+2).
- Results, pair_valid and deg_flag hold their values until the next accepted start or reset.
- op_valid is 0 in IDLE and DONE. Operand outputs hold their last value there.
- No arithmetic is performed in this block beyond the xL==xK equality compare; results are stored bit-exact.

Test Plan:
- Basic solve, N=8, LAT=2: anchors (0,0,r5), (8,0,r5), (0,8,r5); model datapath echoes xK+1 on all result ports after LAT. Required: done in cycle 13; pair_valid=3'b111; deg_flag=0; slots 0-1 hold 1, slots 2-3 hold 1, slots 4-5 hold 9.
- Degenerate pair: anchors (3,0,r4), (3,6,r4), (9,0,r4). Required: deg_flag=3'b001; pair_valid=3'b110; slots 0-1 = 0; done in cycle 1+1+2*(LAT+2) = 10.
- All pairs degenerate: all anchors with x=5. Required: deg_flag=3'b111; pair_valid=0; done in cycle 4; op_valid high only in cycles 1-3.
- start held high continuously through a solve. Required: no restart while busy; a second solve begins in the cycle after DONE returns to IDLE and clears pair_valid on acceptance.
- rst asserted during WAIT of pair 1. Required: next cycle state IDLE, all outputs 0; a subsequent start completes normally in cycle 13.
- LAT=1 and LAT=15 builds with the first scenario's anchors. Required: done in cycles 10 and 52 respectively; operands stable for the whole ISSUE..CAPTURE window of each pair.

Source files
------------

// File: rtl/trilat_pair_scheduler_if.sv
// Bus between the anchor-load front end, the shared circle-intersection
// datapath and the trilateration pair scheduler.
interface trilat_pair_scheduler_if #(
  parameter int N = 8
);
  logic                 start;
  logic [3*N-1:0]       ax;
  logic [3*N-1:0]       ay;
  logic [3*(N+1)-1:0]   ar;
  logic [N-1:0]         xK, yK, xL, yL;
  logic [N:0]           rK, rL;
  logic                 op_valid;
  logic [N+1:0]         x1P, y1P, x2P, y2P;
  logic [6*(N+2)-1:0]   pts_x;
  logic [6*(N+2)-1:0]   pts_y;
  logic [2:0]           pair_valid;
  logic [2:0]           deg_flag;
  logic                 busy;
  logic                 done;

  modport master (
    output start, ax, ay, ar, x1P, y1P, x2P, y2P,
    input  xK, yK, xL, yL, rK, rL, op_valid,
           pts_x, pts_y, pair_valid, deg_flag, busy, done
  );

  modport slave (
    input  start, ax, ay, ar, x1P, y1P, x2P, y2P,
    output xK, yK, xL, yL, rK, rL, op_valid,
           pts_x, pts_y, pair_valid, deg_flag, busy, done
  );
endinterface

// File: rtl/trilat_pair_scheduler.sv
// Time-shares one circle-intersection datapath across anchor pairs (0,1),
// (0,2), (1,2), collecting both intersection points of each pair.
module trilat_pair_scheduler #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  trilat_pair_scheduler_if.slave bus
);
  localparam int W = N + 2;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         pair_q, pair_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               accept, load_ops, degen, capture;
  logic [3*N-1:0]     ax_q, ay_q;
  logic [3*(N+1)-1:0] ar_q;
  logic [3*N-1:0]     src_x, src_y;
  logic [3*(N+1)-1:0] src_r;
  logic [1:0]         k_idx, l_idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pair_d       = pair_q;
    wcnt_d       = wcnt_q;
    accept       = 1'b0;
    load_ops     = 1'b0;
    degen        = 1'b0;
    capture      = 1'b0;
    bus.op_valid = 1'b0;
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          pair_d   = 2'd0;
          load_ops = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus.op_valid = 1'b1;
        // A vertical pair has no defined intersection; skip without waiting.
        if (bus.xK == bus.xL) begin
          degen = 1'b1;
          if (pair_q == 2'd2) begin
            state_d = DONE;
          end else begin
            pair_d   = pair_q + 2'd1;
            load_ops = 1'b1;
            state_d  = ISSUE;
          end
        end else begin
          wcnt_d  = 4'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        bus.op_valid = 1'b1;
        if (wcnt_q == 4'd1) state_d = CAPTURE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      CAPTURE: begin
        bus.op_valid = 1'b1;
        capture      = 1'b1;
        if (pair_q == 2'd2) begin
          state_d = DONE;
        end else begin
          pair_d   = pair_q + 2'd1;
          load_ops = 1'b1;
          state_d  = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pair_q  <= 2'd0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Operands for a new solve come straight from the inputs on the accepting edge.
  assign src_x = accept ? bus.ax : ax_q;
  assign src_y = accept ? bus.ay : ay_q;
  assign src_r = accept ? bus.ar : ar_q;
  assign k_idx = (pair_d == 2'd2) ? 2'd1 : 2'd0;
  assign l_idx = (pair_d == 2'd0) ? 2'd1 : 2'd2;

  // NOTE: the result bank is cleared by reset because downstream reads it as pair_valid-qualified data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ax_q           <= '0;
      ay_q           <= '0;
      ar_q           <= '0;
      bus.xK         <= '0;
      bus.yK         <= '0;
      bus.rK         <= '0;
      bus.xL         <= '0;
      bus.yL         <= '0;
      bus.rL         <= '0;
      bus.pts_x      <= '0;
      bus.pts_y      <= '0;
      bus.pair_valid <= '0;
      bus.deg_flag   <= '0;
    end else begin
      if (accept) begin
        ax_q           <= bus.ax;
        ay_q           <= bus.ay;
        ar_q           <= bus.ar;
        bus.pts_x      <= '0;
        bus.pts_y      <= '0;
        bus.pair_valid <= '0;
        bus.deg_flag   <= '0;
      end
      if (load_ops) begin
        bus.xK <= src_x[int'(k_idx)*N +: N];
        bus.yK <= src_y[int'(k_idx)*N +: N];
        bus.rK <= src_r[int'(k_idx)*(N+1) +: N+1];
        bus.xL <= src_x[int'(l_idx)*N +: N];
        bus.yL <= src_y[int'(l_idx)*N +: N];
        bus.rL <= src_r[int'(l_idx)*(N+1) +: N+1];
      end
      if (degen) bus.deg_flag[pair_q] <= 1'b1;
      if (capture) begin
        bus.pts_x[(2*int'(pair_q))*W +: W]     <= bus.x1P;
        bus.pts_y[(2*int'(pair_q))*W +: W]     <= bus.y1P;
        bus.pts_x[(2*int'(pair_q)+1)*W +: W]   <= bus.x2P;
        bus.pts_y[(2*int'(pair_q)+1)*W +: W]   <= bus.y2P;
        bus.pair_valid[pair_q]                 <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trilat_pair_scheduler.sv
// Drives three scheduler builds (LAT = 2, 1, 15) in lockstep and checks each
// against a cycle-timeline and result model derived from the pair rules.
module tb_trilat_pair_scheduler;
  localparam int N   = 8;
  localparam int NI  = 3;
  localparam int OPW = 6*N + 2;
  localparam int PW  = 6*(N+2);

  logic clk = 1'b0;
  logic rst, start;
  logic [3*N-1:0]     ax, ay;
  logic [3*(N+1)-1:0] ar;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wire           done_a [NI];
  wire           busy_a [NI];
  wire           opv_a  [NI];
  wire [2:0]     pv_a   [NI];
  wire [2:0]     deg_a  [NI];
  wire [PW-1:0]  px_a   [NI];
  wire [PW-1:0]  py_a   [NI];
  wire [OPW-1:0] ops_a  [NI];

  // Datapath stand-in: x1=xK+1, y1=yK+rK, x2=xL+1, y2=yL-rL (all signed, N+2 bits).
  function automatic logic [4*(N+2)-1:0] dp(input logic signed [N-1:0] xk, yk, xl, yl,
                                            input logic signed [N:0] rk, rl);
    logic signed [N+1:0] x1, y1, x2, y2;
    x1 = (N+2)'(xk) + (N+2)'(1);
    y1 = (N+2)'(yk) + (N+2)'(rk);
    x2 = (N+2)'(xl) + (N+2)'(1);
    y2 = (N+2)'(yl) - (N+2)'(rl);
    return {y2, x2, y1, x1};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    trilat_pair_scheduler_if #(.N(N)) bus ();
    trilat_pair_scheduler #(.N(N), .LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [OPW-1:0]       ops;
    logic [OPW-1:0]       hold = '0;
    int                   age  = 0;
    logic [4*(N+2)-1:0]   good;

    assign bus.start = start;
    assign bus.ax    = ax;
    assign bus.ay    = ay;
    assign bus.ar    = ar;
    assign ops  = {bus.xK, bus.yK, bus.rK, bus.xL, bus.yL, bus.rL};
    assign good = dp(bus.xK, bus.yK, bus.xL, bus.yL, bus.rK, bus.rL);
    // Result is only correct once operands have been held for L cycles.
    assign {bus.y2P, bus.x2P, bus.y1P, bus.x1P} = (age >= L) ? good : ~good;

    always @(posedge clk) begin
      if (!bus.op_valid)   age <= 0;
      else if (ops != hold) begin
        age  <= 1;
        hold <= ops;
      end else if (age < 100) age <= age + 1;
    end

    assign done_a[g] = bus.done;
    assign busy_a[g] = bus.busy;
    assign opv_a[g]  = bus.op_valid;
    assign pv_a[g]   = bus.pair_valid;
    assign deg_a[g]  = bus.deg_flag;
    assign px_a[g]   = bus.pts_x;
    assign py_a[g]   = bus.pts_y;
    assign ops_a[g]  = ops;
  end

  function automatic logic [N-1:0] axv(input int i); return ax[i*N +: N]; endfunction
  function automatic logic [N-1:0] ayv(input int i); return ay[i*N +: N]; endfunction
  function automatic logic [N:0]   arv(input int i); return ar[i*(N+1) +: N+1]; endfunction
  function automatic int pk(input int j); return (j == 2) ? 1 : 0; endfunction
  function automatic int pl(input int j); return (j == 0) ? 1 : 2; endfunction

  function automatic logic [OPW-1:0] exp_ops(input int j);
    return {axv(pk(j)), ayv(pk(j)), arv(pk(j)), axv(pl(j)), ayv(pl(j)), arv(pl(j))};
  endfunction

  task automatic set_anchor(input int i, input int x, input int y, input int r);
    ax[i*N +: N]         = N'(x);
    ay[i*N +: N]         = N'(y);
    ar[i*(N+1) +: N+1]   = (N+1)'(r);
  endtask

  task automatic check_idle(input string name);
    for (int g = 0; g < NI; g++) begin
      n_vec++;
      if ({done_a[g], busy_a[g], opv_a[g], pv_a[g], deg_a[g]} !== 9'd0 ||
          px_a[g] !== '0 || py_a[g] !== '0 || ops_a[g] !== '0) begin
        n_err++;
        $display("FAIL %s inst%0d: ctl=%b pv=%b deg=%b px=%h py=%h ops=%h, want all zero",
                 name, g, {done_a[g], busy_a[g], opv_a[g]}, pv_a[g], deg_a[g],
                 px_a[g], py_a[g], ops_a[g]);
      end
    end
  endtask

  // Start a solve with the current anchors; start is sampled at edge 0 and
  // cycle c is the interval following edge c-1.
  task automatic run_solve(input string name, input bit hold_start);
    logic [2:0]          edeg;
    logic [PW-1:0]       epx, epy;
    logic [4*(N+2)-1:0]  r;
    logic [2:0]          ctl, ectl;
    int k, l, acc, ep, lat, cost;
    edeg = '0; epx = '0; epy = '0;
    for (int j = 0; j < 3; j++) begin
      k = pk(j); l = pl(j);
      if (axv(k) == axv(l)) edeg[j] = 1'b1;
      else begin
        r = dp(axv(k), ayv(k), axv(l), ayv(l), arv(k), arv(l));
        epx[(2*j)*(N+2) +: N+2]   = r[0 +: N+2];
        epy[(2*j)*(N+2) +: N+2]   = r[(N+2) +: N+2];
        epx[(2*j+1)*(N+2) +: N+2] = r[2*(N+2) +: N+2];
        epy[(2*j+1)*(N+2) +: N+2] = r[3*(N+2) +: N+2];
      end
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 58; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      for (int g = 0; g < NI; g++) begin
        lat = lat_of(g); acc = 1; ep = -1;
        for (int j = 0; j < 3; j++) begin
          cost = edeg[j] ? 1 : lat + 2;
          if (c >= acc && c < acc + cost) ep = j;
          acc += cost;
        end
        ctl  = {opv_a[g], busy_a[g], done_a[g]};
        ectl = {ep >= 0, c <= acc, c == acc};
        if (hold_start && c > acc) begin
          if (c == acc + 1) begin
            n_vec++;
            if (busy_a[g] !== 1'b0) begin
              n_err++;
              $display("FAIL %s inst%0d idle-gap cyc%0d busy=%b want 0", name, g, c, busy_a[g]);
            end
          end else if (c == acc + 2) begin
            n_vec++;
            if ({busy_a[g], opv_a[g], pv_a[g], deg_a[g]} !== 8'b11_000_000) begin
              n_err++;
              $display("FAIL %s inst%0d restart cyc%0d busy/opv/pv/deg=%b want 11000000",
                       name, g, c, {busy_a[g], opv_a[g], pv_a[g], deg_a[g]});
            end
          end
        end else begin
          n_vec++;
          if (ctl !== ectl) begin
            n_err++;
            $display("FAIL %s inst%0d ctl cyc%0d opv/busy/done=%b want %b", name, g, c, ctl, ectl);
          end
          if (ep >= 0) begin
            n_vec++;
            if (ops_a[g] !== exp_ops(ep)) begin
              n_err++;
              $display("FAIL %s inst%0d operands cyc%0d got %h want %h", name, g, c,
                       ops_a[g], exp_ops(ep));
            end
          end
        end
      end
    end
    if (!hold_start) begin
      for (int g = 0; g < NI; g++) begin
        n_vec++;
        if ({pv_a[g], deg_a[g]} !== {~edeg, edeg}) begin
          n_err++;
          $display("FAIL %s inst%0d flags pv/deg=%b/%b want %b/%b", name, g,
                   pv_a[g], deg_a[g], ~edeg, edeg);
        end
        n_vec++;
        if (px_a[g] !== epx) begin
          n_err++;
          $display("FAIL %s inst%0d pts_x got %h want %h", name, g, px_a[g], epx);
        end
        n_vec++;
        if (py_a[g] !== epy) begin
          n_err++;
          $display("FAIL %s inst%0d pts_y got %h want %h", name, g, py_a[g], epy);
        end
      end
    end
  endtask

  task automatic basic_anchors();
    set_anchor(0, 0, 0, 5);
    set_anchor(1, 8, 0, 5);
    set_anchor(2, 0, 8, 5);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    basic_anchors();
    @(negedge clk);
    check_idle("reset_with_start");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_basic();
    basic_anchors();
    run_solve("basic", 1'b0);
  endtask

  task automatic test_degenerate();
    set_anchor(0, 3, 0, 4);
    set_anchor(1, 3, 6, 4);
    set_anchor(2, 9, 0, 4);
    run_solve("degenerate", 1'b0);
  endtask

  task automatic test_all_degenerate();
    set_anchor(0, 5, 1, 7);
    set_anchor(1, 5, 40, 9);
    set_anchor(2, 5, -20, 3);
    run_solve("all_degenerate", 1'b0);
  endtask

  task automatic test_start_held();
    basic_anchors();
    run_solve("start_held", 1'b1);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    check_idle("held_cleanup");
  endtask

  task automatic test_reset_mid_solve();
    basic_anchors();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({opv_a[0], busy_a[0], pv_a[0]} !== 5'b11_001) begin
      n_err++;
      $display("FAIL mid_solve pre-reset opv/busy/pv=%b want 11001", {opv_a[0], busy_a[0], pv_a[0]});
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_solve_reset");
    rst = 1'b0;
    run_solve("reset_recover", 1'b0);
  endtask

  task automatic test_random();
    int x;
    for (int i = 0; i < 25; i++) begin
      for (int a = 0; a < 3; a++) begin
        x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
        set_anchor(a, x, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)));
      end
      run_solve("random", 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    ax = '0; ay = '0; ar = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_degenerate();
    test_all_degenerate();
    test_start_held();
    test_reset_mid_solve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
